// File: rtl/core_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decode-side output.
// The master modport is the fetch stage; the slave modport is its environment (memory, execute, decode).
interface core_fetch_if;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_imem_rsp_fault;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_d_valid;
    logic        i_d_ready;
    logic [31:0] o_d_pc;
    logic [31:0] o_d_instr;
    logic [31:0] o_d_next_seq_pc;
    logic        o_d_fault;

    modport master (
        output o_imem_req_valid, o_imem_req_addr,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_fault,
        input  i_redirect_valid, i_redirect_pc,
        output o_d_valid, o_d_pc, o_d_instr, o_d_next_seq_pc, o_d_fault,
        input  i_d_ready
    );

    modport slave (
        input  o_imem_req_valid, o_imem_req_addr,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_fault,
        output i_redirect_valid, i_redirect_pc,
        input  o_d_valid, o_d_pc, o_d_instr, o_d_next_seq_pc, o_d_fault,
        output i_d_ready
    );
endinterface

// File: rtl/core_fetch.sv
// LETC instruction fetch stage: owns the fetch PC, keeps one word-aligned request in flight,
// and hands each instruction to decode with its PC and next-sequential PC.
package core_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

module core_fetch #(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    core_fetch_if.master io_bus
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] w_pcNext;
    logic        r_dValid;
    logic        w_dValidNext;
    logic [31:0] r_dPc;
    logic [31:0] r_dInstr;
    logic [31:0] r_dNextSeqPc;
    logic        r_dFault;
    logic        w_free;
    logic        w_reqHs;
    logic        w_load;
    logic [31:0] w_pcPlus4;

    assign w_free    = !r_dValid || io_bus.i_d_ready;
    assign w_pcPlus4 = r_pc + 32'd4;

    // Requests are held off while in reset so nothing is presented before the first clock.
    assign io_bus.o_imem_req_valid = i_rst_n && (r_state == S_REQ) && w_free;
    assign io_bus.o_imem_req_addr  = r_pc;
    assign w_reqHs = io_bus.o_imem_req_valid && io_bus.i_imem_req_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_pcNext     = r_pc;
        w_load       = 1'b0;
        w_dValidNext = r_dValid;

        if (io_bus.i_redirect_valid) begin
            // A redirect wins; any response still owed to an old address must be swallowed in DROP.
            w_pcNext     = {io_bus.i_redirect_pc[31:2], 2'b00};
            w_dValidNext = 1'b0;
            unique case (r_state)
                S_REQ:   w_stateNext = w_reqHs ? S_DROP : S_REQ;
                S_WAIT:  w_stateNext = io_bus.i_imem_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  w_stateNext = io_bus.i_imem_rsp_valid ? S_REQ : S_DROP;
                default: w_stateNext = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_reqHs) begin
                        w_stateNext = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io_bus.i_imem_rsp_valid) begin
                        w_load      = 1'b1;
                        w_pcNext    = w_pcPlus4;
                        w_stateNext = S_REQ;
                    end
                end
                S_DROP: begin
                    if (io_bus.i_imem_rsp_valid) begin
                        w_stateNext = S_REQ;
                    end
                end
                default: w_stateNext = S_REQ;
            endcase

            if (w_load) begin
                w_dValidNext = 1'b1;
            end else if (r_dValid && io_bus.i_d_ready) begin
                w_dValidNext = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dValid     <= 1'b0;
            r_dPc        <= 32'd0;
            r_dInstr     <= 32'd0;
            r_dNextSeqPc <= 32'd0;
            r_dFault     <= 1'b0;
        end else begin
            r_dValid <= w_dValidNext;
            if (w_load) begin
                r_dPc        <= r_pc;
                r_dInstr     <= io_bus.i_imem_rsp_data;
                r_dNextSeqPc <= w_pcPlus4;
                r_dFault     <= io_bus.i_imem_rsp_fault;
            end
        end
    end

    assign io_bus.o_d_valid       = r_dValid;
    assign io_bus.o_d_pc          = r_dPc;
    assign io_bus.o_d_instr       = r_dInstr;
    assign io_bus.o_d_next_seq_pc = r_dNextSeqPc;
    assign io_bus.o_d_fault       = r_dFault;
endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: a behavioural memory and a transaction-level fetch model predict every
// request and every instruction handed to decode, under directed scenarios and random traffic.
module tb_core_fetch;
    logic clk = 1'b0;
    logic rstN;

    core_fetch_if bus ();

    core_fetch dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] expPc;
    logic        expDValid;
    logic [31:0] expDPc;
    logic [31:0] expDInstr;
    logic [31:0] expDNext;
    logic        expDFault;
    int          pendCnt;
    logic        pendStale;
    logic [31:0] rspAddr;
    int          memLat;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic faultOf(input logic [31:0] a);
        return (a == 32'h0000_0008) || (a[6:2] == 5'd19);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs();
        checkOutput("d_valid", {31'd0, bus.o_d_valid}, {31'd0, expDValid});
        checkOutput("d_pc", bus.o_d_pc, expDPc);
        checkOutput("d_instr", bus.o_d_instr, expDInstr);
        checkOutput("d_next_seq_pc", bus.o_d_next_seq_pc, expDNext);
        checkOutput("d_fault", {31'd0, bus.o_d_fault}, {31'd0, expDFault});
    endtask

    task automatic checkReset();
        checkOutput("rst_req_valid", {31'd0, bus.o_imem_req_valid}, 32'd0);
        checkOutput("rst_req_addr", bus.o_imem_req_addr, 32'h0000_0000);
        checkOutput("rst_d_valid", {31'd0, bus.o_d_valid}, 32'd0);
        checkOutput("rst_d_pc", bus.o_d_pc, 32'd0);
        checkOutput("rst_d_instr", bus.o_d_instr, 32'd0);
        checkOutput("rst_d_next_seq_pc", bus.o_d_next_seq_pc, 32'd0);
        checkOutput("rst_d_fault", {31'd0, bus.o_d_fault}, 32'd0);
    endtask

    task automatic resetModel();
        expPc     = 32'h0000_0000;
        expDValid = 1'b0;
        expDPc    = 32'd0;
        expDInstr = 32'd0;
        expDNext  = 32'd0;
        expDFault = 1'b0;
        pendCnt   = 0;
        pendStale = 1'b0;
        rspAddr   = 32'd0;
    endtask

    // One clock cycle: drive at negedge, check the request side, advance the model at posedge,
    // then check the decode-side registers at the following negedge.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                 input logic dRdy, input logic mRdy);
        logic        expReq;
        logic        rspNow;
        logic        hs;
        logic        delivered;
        logic [31:0] oldPc;
        rspNow = (pendCnt == 1);
        bus.i_redirect_valid = redir;
        bus.i_redirect_pc    = rpc;
        bus.i_d_ready        = dRdy;
        bus.i_imem_req_ready = mRdy;
        bus.i_imem_rsp_valid = rspNow;
        bus.i_imem_rsp_data  = rspNow ? instrOf(rspAddr) : $urandom;
        bus.i_imem_rsp_fault = rspNow ? faultOf(rspAddr) : 1'($urandom_range(1, 0));
        expReq = (pendCnt == 0) && (!expDValid || dRdy);
        #1;
        checkOutput("req_valid", {31'd0, bus.o_imem_req_valid}, {31'd0, expReq});
        checkOutput("req_addr", bus.o_imem_req_addr, expPc);
        @(posedge clk);
        hs        = expReq && mRdy;
        delivered = rspNow && !pendStale && !redir;
        oldPc     = expPc;
        if (redir) begin
            expDValid = 1'b0;
        end else if (delivered) begin
            expDValid = 1'b1;
            expDPc    = rspAddr;
            expDInstr = instrOf(rspAddr);
            expDNext  = rspAddr + 32'd4;
            expDFault = faultOf(rspAddr);
        end else if (expDValid && dRdy) begin
            expDValid = 1'b0;
        end
        if (redir) expPc = rpc & ~32'h3;
        else if (delivered) expPc = rspAddr + 32'd4;
        if (pendCnt > 0) pendCnt--;
        if (hs) begin
            pendCnt   = memLat;
            rspAddr   = oldPc;
            pendStale = redir;
        end else if (redir && pendCnt > 0) begin
            pendStale = 1'b1;
        end
        @(negedge clk);
        checkRegs();
    endtask

    initial begin
        rstN = 1'b0;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'd0;
        bus.i_d_ready        = 1'b1;
        bus.i_imem_req_ready = 1'b1;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'd0;
        bus.i_imem_rsp_fault = 1'b0;
        memLat = 1;
        resetModel();
        repeat (2) @(negedge clk);
        checkReset();
        rstN = 1'b1;
        $display("[TB] reset released");

        // Streaming fetch with zero-wait memory; 0x8 returns a fault and fetch carries on.
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Decode stall with an instruction held in the output register.
        for (int k = 0; k < 10 && !expDValid; k++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect while waiting on a slow response.
        memLat = 3;
        for (int k = 0; k < 10 && pendCnt == 0; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect in the same cycle as the response.
        memLat = 2;
        for (int k = 0; k < 10 && pendCnt != 1; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect in the same cycle as a request handshake.
        for (int k = 0; k < 10 && (pendCnt != 0 || expDValid); k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // PC wrap at the top of the address space.
        memLat = 1;
        for (int k = 0; k < 10 && pendCnt != 0; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of traffic.
        #2 rstN = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        #1 checkReset();
        resetModel();
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        $display("[TB] random phase");
        for (int n = 0; n < 1500; n++) begin
            logic        r;
            logic [31:0] rpc;
            memLat = int'($urandom_range(4, 1));
            r      = ($urandom_range(11, 0) == 0);
            rpc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            applyStimulus(r, rpc, ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
